md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, SHALL set the busy duration of mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, SHALL set the busy duration of div/divu.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be the E-stage request qualifier for op.
REQ-006 op  input  3  SHALL select the operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 no-op.
REQ-007 rs_val  input  32  SHALL carry the forwarded E-stage rs operand (dividend or multiplicand).
REQ-008 rt_val  input  32  SHALL carry the forwarded E-stage rt operand (divisor or multiplier).
REQ-009 md_use_D  input  1  SHALL flag that the D-stage instruction is a mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 busy  output  1  SHALL be high while a multi-cycle operation is in progress.
REQ-011 stall  output  1  SHALL be a stall request to the hazard unit.
REQ-012 done  output  1  SHALL be a one-cycle pulse when HI/LO take a multi-cycle result.
REQ-013 hi, lo  output  32 each  SHALL present the architectural HI/LO registers.

Function
REQ-014 The block SHALL use states IDLE, MUL and DIV, plus a 4-bit down-counter and two 32-bit result holding registers.
REQ-015 In IDLE, start with op 0/1 SHALL latch the 64-bit product of rs_val*rt_val (signed for 0, unsigned for 1), load the counter with MULT_CYCLES-1, and go to MUL.
REQ-016 In IDLE, start with op 2/3 SHALL latch quotient/remainder (signed for 2, unsigned for 3), load the counter with DIV_CYCLES-1, and go to DIV.
REQ-017 Signed division SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-018 In MUL/DIV, the counter SHALL decrement once per cycle; at counter==0 the block SHALL write hi<=upper/remainder and lo<=lower/quotient, pulse done, and return to IDLE.
REQ-019 busy SHALL be registered: high exactly MULT_CYCLES (or DIV_CYCLES) cycles, starting the cycle after the start edge.
REQ-020 hi/lo SHALL update on the edge where busy falls; the first following cycle SHALL observe the new values.
REQ-021 Division by zero SHALL still take DIV_CYCLES with busy high, assert done, and leave hi/lo unchanged.
REQ-022 In IDLE, start with op 4 SHALL write hi<=rs_val, and op 5 SHALL write lo<=rs_val, on the same edge, with no busy and no done.
REQ-023 start while busy SHALL be ignored: no state, counter, hi or lo change.
REQ-024 start with op 6/7 SHALL be ignored.
REQ-025 stall SHALL be combinational, equal to md_use_D & (busy | (start & op<=3)).
REQ-026 The counter SHALL never wrap; reaching 0 outside MUL/DIV SHALL hold at 0.
REQ-027 Operands SHALL be captured at the start edge only; later changes on rs_val/rt_val SHALL NOT affect the result.

Reset
REQ-028 reset low SHALL immediately force state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, and clear the holding registers.
REQ-029 reset asserted mid-operation SHALL discard the pending result; after release, hi/lo SHALL read 0 and no done pulse SHALL occur.
REQ-030 The first start accepted after release SHALL be the first clk edge with reset high.

Verification
REQ-031 mult rs=0xFFFFFFFE, rt=3 -> busy high 5 cycles, done once, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 multu rs=0xFFFFFFFE, rt=3 -> hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
REQ-033 div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 After mthi 0x1234 and mtlo 0x5678, divu rs=7, rt=0 -> busy 10 cycles, done pulses, hi=0x1234, lo=0x5678.
REQ-035 During a div (busy cycle 3), apply mult start -> ignored; div result correct; stall=1 while md_use_D=1 and busy=1.
REQ-036 reset low during busy cycle 3 of a mult -> busy=0, hi=lo=0 at once; no done pulse after release.

Source files
------------

// File: rtl/md_ctrl_if.sv
// Handshake and result bundle between the E-stage and the HI/LO multiply/divide controller.
interface md_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_D;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, md_use_D,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, md_use_D,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide controller owning the architectural HI/LO registers.
// The result is computed at the start edge, held, and committed when the busy window ends.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_ctrl_if.slave io
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  // Returns {upper, lower} of the 64-bit product.
  function automatic logic [63:0] f_mul(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic signed [63:0] a_s;
    logic signed [63:0] b_s;
    logic        [63:0] p;
    if (sgn) begin
      a_s = {{32{a[31]}}, a};
      b_s = {{32{b[31]}}, b};
      p   = a_s * b_s;
    end else begin
      p   = {32'd0, a} * {32'd0, b};
    end
    return p;
  endfunction

  // Returns {remainder, quotient}; signed form truncates toward zero.
  function automatic logic [63:0] f_div(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic        [31:0] q;
    logic        [31:0] r;
    a_s = a;
    b_s = b;
    if (sgn) begin
      q = a_s / b_s;
      r = a_s % b_s;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_hold_hi;
  logic [31:0] r_hold_lo;

  logic [63:0] w_prod;
  logic [63:0] w_divres;
  logic        w_div_zero;

  assign w_prod     = f_mul(io.rs_val, io.rt_val, ~io.op[0]);
  assign w_div_zero = (io.rt_val == 32'd0);
  assign w_divres   = w_div_zero ? {r_hi, r_lo}
                                 : f_div(io.rs_val, io.rt_val, ~io.op[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_hold_hi <= 32'd0;
      r_hold_lo <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io.start) begin
            case (io.op)
              3'd0, 3'd1: begin
                r_hold_hi <= w_prod[63:32];
                r_hold_lo <= w_prod[31:0];
                r_cnt     <= 4'(MULT_CYCLES - 1);
                r_busy    <= 1'b1;
                r_state   <= MUL;
              end
              3'd2, 3'd3: begin
                // A zero divisor holds the current HI/LO so the commit is a no-op.
                r_hold_hi <= w_divres[63:32];
                r_hold_lo <= w_divres[31:0];
                r_cnt     <= 4'(DIV_CYCLES - 1);
                r_busy    <= 1'b1;
                r_state   <= DIV;
              end
              3'd4:    r_hi <= io.rs_val;
              3'd5:    r_lo <= io.rs_val;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (r_cnt == 4'd0) begin
            r_hi    <= r_hold_hi;
            r_lo    <= r_hold_lo;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io.busy  = r_busy;
  assign io.done  = r_done;
  assign io.hi    = r_hi;
  assign io.lo    = r_lo;
  assign io.stall = io.md_use_D & (r_busy | (io.start & (io.op <= 3'd3)));

endmodule

// File: tb/tb_md_ctrl.sv
// Directed-vector bench for md_ctrl: mult/div results, busy/done timing, mthi/mtlo,
// ignored starts, stall logic and asynchronous reset behaviour.
module tb_md_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_mis;

  md_ctrl_if u_if ();

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multi-cycle op, then watch busy/done for a bounded window.
  // With inject set, a mult start is applied during busy cycle 3 and must be ignored.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit inject);
    int          nb;
    int          nd;
    logic [31:0] cap_hi;
    logic [31:0] cap_lo;
    logic        cap_busy;
    nb       = 0;
    nd       = 0;
    cap_hi   = 32'hxxxxxxxx;
    cap_lo   = 32'hxxxxxxxx;
    cap_busy = 1'bx;
    u_if.start  = 1'b1;
    u_if.op     = op;
    u_if.rs_val = rs;
    u_if.rt_val = rt;
    tick();
    u_if.start  = 1'b0;
    u_if.rs_val = 32'hA5A5_0F0F;
    u_if.rt_val = 32'h0000_0001;
    for (int i = 0; i < 24; i++) begin
      if (i == 3) begin
        u_if.start = 1'b0;
        u_if.op    = op;
      end
      if (u_if.busy) nb++;
      if (u_if.done) begin
        nd++;
        cap_hi   = u_if.hi;
        cap_lo   = u_if.lo;
        cap_busy = u_if.busy;
      end
      if (inject && i == 2) begin
        u_if.md_use_D = 1'b1;
        u_if.start    = 1'b1;
        u_if.op       = 3'd0;
        u_if.rs_val   = 32'd5;
        u_if.rt_val   = 32'd5;
        #1;
        chk({tag, " stall_busy"}, 32'(u_if.stall), 32'd1);
        u_if.md_use_D = 1'b0;
      end
      tick();
    end
    chk({tag, " busy_cycles"}, nb, exp_busy);
    chk({tag, " done_pulses"}, nd, 32'd1);
    chk({tag, " busy_at_done"}, 32'(cap_busy), 32'd0);
    chk({tag, " hi"}, cap_hi, exp_hi);
    chk({tag, " lo"}, cap_lo, exp_lo);
  endtask

  initial begin
    int nd;
    n_vec = 0;
    n_mis = 0;
    reset         = 1'b0;
    u_if.start    = 1'b0;
    u_if.op       = 3'd7;
    u_if.rs_val   = 32'd0;
    u_if.rt_val   = 32'd0;
    u_if.md_use_D = 1'b0;
    tick();
    tick();
    chk("rst busy", 32'(u_if.busy), 32'd0);
    chk("rst done", 32'(u_if.done), 32'd0);
    chk("rst hi", u_if.hi, 32'd0);
    chk("rst lo", u_if.lo, 32'd0);
    reset = 1'b1;
    tick();

    // Combinational stall decode
    u_if.md_use_D = 1'b1; u_if.start = 1'b1; u_if.op = 3'd3; #1;
    chk("stall divu", 32'(u_if.stall), 32'd1);
    u_if.op = 3'd4; #1;
    chk("stall mthi", 32'(u_if.stall), 32'd0);
    u_if.md_use_D = 1'b0; u_if.op = 3'd0; #1;
    chk("stall no_use", 32'(u_if.stall), 32'd0);
    u_if.start = 1'b0;
    tick();

    run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5,  32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_negdvs", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu",  3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);

    // mthi / mtlo write on the start edge with no busy or done
    u_if.start = 1'b1; u_if.op = 3'd4; u_if.rs_val = 32'h1234;
    tick();
    chk("mthi hi", u_if.hi, 32'h1234);
    chk("mthi busy", 32'(u_if.busy), 32'd0);
    u_if.op = 3'd5; u_if.rs_val = 32'h5678;
    tick();
    chk("mtlo lo", u_if.lo, 32'h5678);
    chk("mtlo hi", u_if.hi, 32'h1234);
    chk("mtlo done", 32'(u_if.done), 32'd0);
    u_if.op = 3'd6; u_if.rs_val = 32'hDEAD_BEEF;
    tick();
    chk("op6 busy", 32'(u_if.busy), 32'd0);
    chk("op6 hi", u_if.hi, 32'h1234);
    chk("op6 lo", u_if.lo, 32'h5678);
    u_if.start = 1'b0;
    tick();

    run_op("divu_by0", 3'd3, 32'd7, 32'd0, 10, 32'h1234, 32'h5678, 1'b0);
    run_op("div_inject", 3'd2, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b1);

    // Asynchronous reset in busy cycle 3 of a mult
    u_if.start = 1'b1; u_if.op = 3'd0; u_if.rs_val = 32'hFFFF_FFFE; u_if.rt_val = 32'd3;
    tick();
    u_if.start = 1'b0;
    tick();
    tick();
    chk("mid busy_before", 32'(u_if.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid rst busy", 32'(u_if.busy), 32'd0);
    chk("mid rst hi", u_if.hi, 32'd0);
    chk("mid rst lo", u_if.lo, 32'd0);
    tick();
    reset = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (u_if.done) nd++;
    end
    chk("mid no_done", nd, 32'd0);
    chk("mid post hi", u_if.hi, 32'd0);
    chk("mid post lo", u_if.lo, 32'd0);

    // Start on the first edge with reset released
    reset = 1'b0;
    tick();
    reset = 1'b1;
    run_op("first_edge", 3'd0, 32'd2, 32'd3, 5, 32'd0, 32'd6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
